// File: rtl/gate_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : gate_pipe_unit
//  Description : WIDTH-bit op-selectable bitwise logic unit behind a two-stage
//                valid/ready pipeline, with reduction flags, an illegal-op
//                flag and a saturating count of completed output transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_red_and,
    output logic             out_red_or,
    output logic             out_red_xor,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] c_op_and  = 3'd0;
    localparam logic [2:0] c_op_or   = 3'd1;
    localparam logic [2:0] c_op_xor  = 3'd2;
    localparam logic [2:0] c_op_nand = 3'd3;
    localparam logic [2:0] c_op_nor  = 3'd4;
    localparam logic [2:0] c_op_xnor = 3'd5;
    localparam logic [2:0] c_op_nota = 3'd6;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Stage 1 holds the raw operands; stage 2 holds the finished result.
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_red_and;
    logic             r_red_or;
    logic             r_red_xor;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_y;
    logic             w_illegal;

    // Backpressure ripples straight from the consumer; there is no skid buffer,
    // so in_ready is combinational from out_ready.
    always_comb begin
        w_s2_adv   = !r_s2_valid || out_ready;
        w_s1_adv   = !r_s1_valid || w_s2_adv;
        w_out_xfer = r_s2_valid && out_ready;
    end

    // Bitwise operation on the stage-1 operands; the reserved code yields zero.
    always_comb begin
        w_y       = '0;
        w_illegal = 1'b0;
        case (r_s1_op)
            c_op_and  : w_y = r_s1_a & r_s1_b;
            c_op_or   : w_y = r_s1_a | r_s1_b;
            c_op_xor  : w_y = r_s1_a ^ r_s1_b;
            c_op_nand : w_y = ~(r_s1_a & r_s1_b);
            c_op_nor  : w_y = ~(r_s1_a | r_s1_b);
            c_op_xnor : w_y = ~(r_s1_a ^ r_s1_b);
            c_op_nota : w_y = ~r_s1_a;
            default   : begin
                w_y       = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Stage 1: capture operands whenever the stage can move forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= in_a;
                r_s1_b  <= in_b;
                r_s1_op <= in_op;
            end
        end
    end

    // Stage 2: register result and flags; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_red_and  <= 1'b0;
            r_red_or   <= 1'b0;
            r_red_xor  <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y       <= w_y;
                r_red_and <= &w_y;
                r_red_or  <= |w_y;
                r_red_xor <= ^w_y;
                r_illegal <= w_illegal;
            end
        end
    end

    // Count output transfers, sticking at the all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_xfer && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign in_ready    = w_s1_adv;
    assign out_valid   = r_s2_valid;
    assign out_y       = r_y;
    assign out_red_and = r_red_and;
    assign out_red_or  = r_red_or;
    assign out_red_xor = r_red_xor;
    assign out_illegal = r_illegal;
    assign op_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gate_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_pipe_unit
//  Description : Directed self-checking bench for gate_pipe_unit; one 8-bit
//                instance with a 16-bit counter and one 1-bit instance with a
//                4-bit counter share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_pipe_unit;

    logic clk;
    logic rst_n;

    // 8-bit instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_a, a_in_b, a_out_y;
    logic [2:0]  a_in_op;
    logic        a_red_and, a_red_or, a_red_xor, a_illegal;
    logic [15:0] a_count;

    // 1-bit instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]  b_in_a, b_in_b, b_out_y;
    logic [2:0]  b_in_op;
    logic        b_red_and, b_red_or, b_red_xor, b_illegal;
    logic [3:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;

    gate_pipe_unit #(.WIDTH(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y),
        .out_red_and(a_red_and), .out_red_or(a_red_or), .out_red_xor(a_red_xor),
        .out_illegal(a_illegal), .op_count(a_count)
    );

    gate_pipe_unit #(.WIDTH(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y),
        .out_red_and(b_red_and), .out_red_or(b_red_or), .out_red_xor(b_red_xor),
        .out_illegal(b_illegal), .op_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result word of the 8-bit instance: {y, red_and, red_or, red_xor, illegal}
    function automatic logic [11:0] a_word();
        return {a_out_y, a_red_and, a_red_or, a_red_xor, a_illegal};
    endfunction

    logic [7:0]  va   [9];
    logic [7:0]  vb   [9];
    logic [2:0]  vo   [9];
    logic [11:0] vexp [9];
    logic [3:0]  tt_exp [7];
    logic [3:0]  tt_got [7];
    int          bad_valid;

    initial begin
        // Hand-computed stream vectors
        va[0]=8'hA5; vb[0]=8'h0F; vo[0]=3'd2; vexp[0]={8'hAA,4'b0100};
        va[1]=8'hA5; vb[1]=8'h0F; vo[1]=3'd3; vexp[1]={8'hFA,4'b0100};
        va[2]=8'hA5; vb[2]=8'h0F; vo[2]=3'd4; vexp[2]={8'h50,4'b0100};
        va[3]=8'hA5; vb[3]=8'h0F; vo[3]=3'd5; vexp[3]={8'h55,4'b0100};
        va[4]=8'h3C; vb[4]=8'h00; vo[4]=3'd6; vexp[4]={8'hC3,4'b0100};
        va[5]=8'h07; vb[5]=8'h01; vo[5]=3'd1; vexp[5]={8'h07,4'b0110};
        va[6]=8'hFF; vb[6]=8'hFF; vo[6]=3'd0; vexp[6]={8'hFF,4'b1100};
        va[7]=8'h00; vb[7]=8'h00; vo[7]=3'd2; vexp[7]={8'h00,4'b0000};
        va[8]=8'h12; vb[8]=8'h34; vo[8]=3'd7; vexp[8]={8'h00,4'b0001};
        // Truth tables, leftmost bit is ab=00, rightmost ab=11
        tt_exp[0]=4'b0001; tt_exp[1]=4'b0111; tt_exp[2]=4'b0110; tt_exp[3]=4'b1110;
        tt_exp[4]=4'b1000; tt_exp[5]=4'b1001; tt_exp[6]=4'b1100;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_in_op = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_op = '0; b_out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_word",      32'(a_word()),    32'd0);
        check("rst_count",     32'(a_count),     32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(a_in_ready),  32'd1);

        // Basic AND with latency 2
        a_in_valid = 1'b1; a_in_a = 8'hF0; a_in_b = 8'h3C; a_in_op = 3'd0;
        tick();
        a_in_valid = 1'b0;
        check("t1_lat1_valid", 32'(a_out_valid), 32'd0);
        tick();
        check("t1_lat2_valid", 32'(a_out_valid), 32'd1);
        check("t1_word",       32'(a_word()),    32'({8'h30, 4'b0100}));
        tick();
        check("t1_drained",    32'(a_out_valid), 32'd0);
        check("t1_count",      32'(a_count),     32'd1);

        // Reserved op
        a_in_valid = 1'b1; a_in_a = 8'hFF; a_in_b = 8'hFF; a_in_op = 3'd7;
        tick();
        a_in_valid = 1'b0;
        tick();
        check("t4_word",  32'(a_word()), 32'({8'h00, 4'b0001}));
        tick();
        check("t4_count", 32'(a_count),  32'd2);

        // Back-to-back stream, one beat per cycle
        bad_valid = 0;
        for (int k = 0; k <= 9; k++) begin
            if (k < 9) begin
                a_in_valid = 1'b1; a_in_a = va[k]; a_in_b = vb[k]; a_in_op = vo[k];
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
            if (k >= 1) begin
                if (a_out_valid !== 1'b1) bad_valid++;
                check($sformatf("stream_%0d", k - 1), 32'(a_word()), 32'(vexp[k-1]));
            end
        end
        check("stream_valid", 32'(bad_valid), 32'd0);
        tick();
        check("stream_count", 32'(a_count), 32'd11);

        // Full stall: two beats buffered, third held off, then drain in order
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_a = 8'hAA; a_in_b = 8'h55; a_in_op = 3'd1;
        #1 check("stall_rdy0", 32'(a_in_ready), 32'd1);
        tick();
        a_in_a = 8'h55; a_in_b = 8'h0F;
        check("stall_rdy1", 32'(a_in_ready), 32'd1);
        tick();
        a_in_a = 8'h0F; a_in_b = 8'hF0;
        check("stall_rdy2", 32'(a_in_ready), 32'd0);
        tick();
        check("stall_hold_rdy", 32'(a_in_ready), 32'd0);
        check("stall_hold_y0",  32'(a_out_y),    32'hFF);
        tick();
        check("stall_hold_y1",  32'(a_out_y),    32'hFF);
        check("stall_count",    32'(a_count),    32'd11);
        a_out_ready = 1'b1;
        #1 check("stall_release_rdy", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        check("drain_y1", 32'(a_out_y), 32'h5F);
        tick();
        check("drain_y2", 32'({a_out_valid, a_out_y}), 32'h1FF);
        tick();
        check("drain_empty", 32'(a_out_valid), 32'd0);
        check("drain_count", 32'(a_count),     32'd14);

        // 1-bit truth tables; 28 transfers also saturate the 4-bit counter
        check("b_count_start", 32'(b_count), 32'd0);
        bad_valid = 0;
        for (int k = 0; k <= 28; k++) begin
            if (k < 28) begin
                b_in_valid = 1'b1;
                b_in_op    = 3'(k / 4);
                b_in_a     = 1'((k % 4) >> 1);
                b_in_b     = 1'(k % 2);
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            if (k >= 1) begin
                if (b_out_valid !== 1'b1) bad_valid++;
                tt_got[(k-1)/4][3 - ((k-1) % 4)] = b_out_y[0];
            end
        end
        tick();
        check("tt_valid", 32'(bad_valid), 32'd0);
        for (int op = 0; op < 7; op++)
            check($sformatf("tt_op%0d", op), 32'(tt_got[op]), 32'(tt_exp[op]));
        check("b_count_sat", 32'(b_count), 32'd15);
        b_in_valid = 1'b1; b_in_a = 1'b1; b_in_b = 1'b1; b_in_op = 3'd0;
        repeat (3) tick();
        b_in_valid = 1'b0;
        repeat (2) tick();
        check("b_count_hold", 32'(b_count), 32'd15);

        // Asynchronous reset with two beats in flight
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_a = 8'h11; a_in_b = 8'h22; a_in_op = 3'd1;
        tick();
        tick();
        a_in_valid = 1'b0;
        check("midrst_pre_valid", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(a_out_valid), 32'd0);
        check("midrst_count", 32'(a_count),     32'd0);
        check("midrst_y",     32'(a_out_y),     32'd0);
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        tick();
        check("post_rst_empty", 32'(a_out_valid), 32'd0);
        a_in_valid = 1'b1; a_in_a = 8'h12; a_in_b = 8'h34; a_in_op = 3'd0;
        tick();
        a_in_valid = 1'b0;
        check("post_rst_lat1", 32'(a_out_valid), 32'd0);
        tick();
        check("post_rst_lat2", 32'({a_out_valid, a_out_y}), 32'h110);
        tick();
        check("post_rst_count", 32'(a_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
